seg7_scan_driver: RTL and testbench

- Output-side companion of the debounced button inputs: drives a 4-digit, common-anode, multiplexed 7-segment display showing the 16-bit result as four hex digits.
- Time-multiplexes the digits with a blanking gap between digits to prevent ghosting.
- Double-buffers the displayed value so a digit never changes mid-frame.
- Supports leading-zero suppression and per-digit decimal points.

---
 rtl/seg7_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scan driver
// Double-buffered hex display with blanking gaps, leading-zero blanking and per-digit dp.
module seg7_scan_driver #(
  parameter int ON_CYCLES    = 50_000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lz_suppress,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [19:0] shadow_q, shadow_d;
  logic [19:0] disp_q, disp_d;
  logic        pending_q, pending_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  an_q, an_d;
  logic        fd_q, fd_d;

  logic        boundary;
  logic [15:0] upper;
  logic [3:0]  dp_bits;
  logic        cur_dp;
  logic        suppressed;
  logic [3:0]  an_sel;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    boundary  = 1'b0;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == ON_LAST) begin
          state_d  = S_BLANK;
          cnt_d    = '0;
          digit_d  = digit_q + 2'd1;
          boundary = (digit_q == 2'd3);
        end
      end
    endcase

    if (load) begin
      shadow_d  = {dp_in, value};
      pending_d = 1'b1;
    end
    // A load landing on the boundary edge itself goes straight to the display.
    if (boundary) begin
      if (load) begin
        disp_d = {dp_in, value};
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end

    upper      = disp_q[15:0] >> {digit_q, 2'b00};
    dp_bits    = disp_q[19:16];
    cur_dp     = dp_bits[digit_q];
    suppressed = lz_suppress && (digit_q != 2'd0) && (upper == 16'h0000);
    an_sel     = ~(4'b0001 << digit_q);

    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = 4'hF;
    fd_d  = boundary;
    if (state_q == S_ON) begin
      if (!suppressed) begin
        an_d  = an_sel;
        seg_d = ~hex_decode(upper[3:0]);
        dp_d  = ~cur_dp;
      end else if (cur_dp) begin
        an_d = an_sel;
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_BLANK;
      cnt_q     <= '0;
      digit_q   <= 2'd0;
      shadow_q  <= 20'h0;
      disp_q    <= 20'h0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= 4'hF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench for seg7_scan_driver against a frame-arithmetic model
// Expected outputs come from cycle position within the frame plus a shadow/pending model of loads.
module tb_seg7_scan_driver;
  localparam int ON   = 8;
  localparam int BL   = 2;
  localparam int SLOT = ON + BL;
  localparam int P    = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  seg7_scan_driver #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .lz_suppress(lz_suppress), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [19:0] m_disp = 20'h0;
  logic [19:0] m_shadow = 20'h0;
  bit          m_pend = 1'b0;
  int          e = 0;
  logic [12:0] exp_out = 13'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output of cycle e reflects the scan position of cycle e-1 and the display before edge e.
  task automatic model_edge();
    int mm, q, d;
    bit on, sup, fd, dpb;
    logic [15:0] hi;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    if (!rst) begin
      e = 0;
      m_disp = 20'h0;
      m_shadow = 20'h0;
      m_pend = 1'b0;
      exp_out = {1'b0, 4'hF, 1'b1, 7'h7F};
    end else begin
      e++;
      mm = e - 1;
      q = mm % P;
      d = q / SLOT;
      on = (q % SLOT) >= BL;
      an = 4'hF; seg = 7'h7F; dp = 1'b1;
      if (on) begin
        hi = m_disp[15:0] >> (4 * d);
        dpb = m_disp[16 + d];
        sup = lz_suppress && (d != 0) && (hi == 16'h0);
        if (!sup) begin
          an = ~(4'b0001 << d);
          seg = ~seg_tab[hi[3:0]];
          dp = ~dpb;
        end else if (dpb) begin
          an = ~(4'b0001 << d);
          dp = 1'b0;
        end
      end
      fd = (e % P) == 0;
      exp_out = {fd, an, dp, seg};
      if (load) m_shadow = {dp_in, value};
      if (fd) begin
        if (load) m_disp = {dp_in, value};
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq($sformatf("out e=%0d", e), {19'b0, frame_done, an_n, dp_n, seg_n}, {19'b0, exp_out});
  endtask

  task automatic run_to(input int target);
    while (e < target) cycle();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int base;
    repeat (5) cycle();
    rst = 1'b1;
    run_to(P + 2);

    run_to(2 * P - 2);
    load_once(16'h12AF, 4'h0);
    run_to(3 * P + 4);

    run_to(3 * P + 14);
    load_once(16'h1234, 4'h0);
    run_to(4 * P + 5);
    load_once(16'h5678, 4'h3);
    run_to(4 * P + 25);
    load_once(16'h9ABC, 4'h8);
    run_to(6 * P);

    lz_suppress = 1'b1;
    load_once(16'h0007, 4'h0);
    run_to(7 * P + 2);
    load_once(16'h0007, 4'b0100);
    run_to(9 * P - 1);

    lz_suppress = 1'b0;
    load_once(16'hBEEF, 4'h0);
    run_to(10 * P + 25);
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    run_to(P + 5);

    base = 0;
    for (int i = 0; i < 2500; i++) begin
      load = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        v = 16'($urandom);
        v = v & (16'hFFFF >> (4 * $urandom_range(0, 4)));
        value = v;
        dp_in = 4'($urandom);
        load = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
      if (!rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
      end
      cycle();
      base++;
    end
    load = 1'b0;
    rst = 1'b1;
    repeat (P) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
